// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding and the iteration-counter width helper.
package div_pkg;

   // Explicit state encodings so waveforms and debug probes read consistently.
   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_RUN  = 2'd1;
   localparam logic [1:0] ENC_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ENC_IDLE,
      RUN  = ENC_RUN,
      DONE = ENC_DONE
   } state_t;

   // The counter must be able to hold values up to WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// master: the requester driving operands; slave: the divider itself.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);
   // One extra bit above the shifted remainder acts as the borrow/sign flag
   // of the trial subtraction.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   assign shifted = {rem, bit_in};
   assign diff    = shifted - {2'b00, divisor};

   // Non-negative difference means the divisor fits: keep it and emit a 1.
   always_comb begin
      q_bit    = ~diff[WIDTH+1];
      rem_next = shifted[WIDTH:0];
      if (q_bit) begin
         rem_next = diff[WIDTH:0];
      end
   end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Divide-by-zero short-circuits to DONE.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  bus
);
   localparam int             CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t state_reg, state_next;

   // Working registers: partial remainder, dividend/quotient shift register,
   // captured divisor and the step counter.
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] dvd_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Result registers, held until the next accepted start.
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] rmd_reg;
   logic             dbz_reg;

   logic             accept;
   logic             step;
   logic             last_step;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   rem_step;
   logic             q_bit;
   logic [WIDTH-1:0] quo_step;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_reg),
      .bit_in   (dvd_reg[WIDTH-1]),
      .divisor  (dsr_reg),
      .rem_next (rem_step),
      .q_bit    (q_bit)
   );

   // The freed dividend LSB collects the new quotient bit.
   assign quo_step = {dvd_reg[WIDTH-2:0], q_bit};

   // Next-state logic and handshake outputs decoded from the current state.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      step       = 1'b0;
      last_step  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = (bus.divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt_reg == LAST) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Working datapath: load on accept, one restoring step per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg <= '0;
         dvd_reg <= '0;
         dsr_reg <= '0;
         cnt_reg <= '0;
      end else if (accept) begin
         rem_reg <= '0;
         dvd_reg <= bus.dividend;
         dsr_reg <= bus.divisor;
         cnt_reg <= '0;
      end else if (step) begin
         rem_reg <= rem_step;
         dvd_reg <= quo_step;
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Results: cleared (or set to the divide-by-zero values) on accept,
   // written from the final step, otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_reg <= '0;
         rmd_reg <= '0;
         dbz_reg <= 1'b0;
      end else if (accept) begin
         if (bus.divisor == '0) begin
            quo_reg <= '1;
            rmd_reg <= bus.dividend;
            dbz_reg <= 1'b1;
         end else begin
            quo_reg <= '0;
            rmd_reg <= '0;
            dbz_reg <= 1'b0;
         end
      end else if (last_step) begin
         quo_reg <= quo_step;
         rmd_reg <= rem_step[WIDTH-1:0];
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quo_reg;
   assign bus.remainder   = rmd_reg;
   assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=4 (directed + exhaustive) and
// WIDTH=8 (random). Stimulus pushes expected results; monitors pop on done.
module tb_seq_divider;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(4)) bus4 ();
   seq_divider_if #(.WIDTH(8)) bus8 ();

   seq_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

   typedef struct {
      int q;
      int r;
      int z;
   } exp_t;

   exp_t sb4[$];
   exp_t sb8[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer division, all-ones/dividend for a zero divisor.
   function automatic exp_t model(input int a, input int b, input int w);
      exp_t e;
      if (b == 0) begin
         e.q = (1 << w) - 1;
         e.r = a;
         e.z = 1;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.z = 0;
      end
      return e;
   endfunction

   // WIDTH=4 monitor: every done must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus4.done) begin
         check("w4 busy low with done", int'(bus4.busy), 0);
         check("w4 done expected", int'(sb4.size() > 0), 1);
         if (sb4.size() > 0) begin
            exp_t e;
            e = sb4.pop_front();
            $display("w4 done q=%0d r=%0d dbz=%0d (exp q=%0d r=%0d dbz=%0d)",
                     bus4.quotient, bus4.remainder, bus4.div_by_zero, e.q, e.r, e.z);
            check("w4 quotient", int'(bus4.quotient), e.q);
            check("w4 remainder", int'(bus4.remainder), e.r);
            check("w4 div_by_zero", int'(bus4.div_by_zero), e.z);
         end
      end
   end

   // WIDTH=8 monitor.
   always @(negedge clk) begin
      if (!rst && bus8.done) begin
         check("w8 busy low with done", int'(bus8.busy), 0);
         check("w8 done expected", int'(sb8.size() > 0), 1);
         if (sb8.size() > 0) begin
            exp_t e;
            e = sb8.pop_front();
            $display("w8 done q=%0d r=%0d dbz=%0d (exp q=%0d r=%0d dbz=%0d)",
                     bus8.quotient, bus8.remainder, bus8.div_by_zero, e.q, e.r, e.z);
            check("w8 quotient", int'(bus8.quotient), e.q);
            check("w8 remainder", int'(bus8.remainder), e.r);
            check("w8 div_by_zero", int'(bus8.div_by_zero), e.z);
         end
      end
   end

   // Wait for IDLE, present operands for one accepting edge. Returns at the
   // first negedge after the accepting edge.
   task automatic issue4(input int a, input int b, input bit push);
      int t;
      t = 0;
      @(negedge clk);
      while ((bus4.busy || bus4.done) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("w4 idle timeout", t, 0);
      bus4.dividend = 4'(a);
      bus4.divisor  = 4'(b);
      bus4.start    = 1'b1;
      if (push) sb4.push_back(model(a, b, 4));
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   task automatic issue8(input int a, input int b);
      int t;
      t = 0;
      @(negedge clk);
      while ((bus8.busy || bus8.done) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("w8 idle timeout", t, 0);
      bus8.dividend = 8'(a);
      bus8.divisor  = 8'(b);
      bus8.start    = 1'b1;
      sb8.push_back(model(a, b, 8));
      @(negedge clk);
      bus8.start = 1'b0;
   endtask

   // Called right after issue4: n counts negedges after the accepting edge.
   task automatic measure4(output int lat, output int busy_cnt);
      int n;
      n = 1;
      busy_cnt = 0;
      while (!bus4.done && n < 40) begin
         if (bus4.busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      lat = n;
   endtask

   initial begin
      int lat;
      int bcnt;
      int first_done;
      int second_done;
      int seen;
      int pa[3];
      int pb[3];

      bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
      bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset busy", int'(bus4.busy), 0);
      check("reset done", int'(bus4.done), 0);
      check("reset quotient", int'(bus4.quotient), 0);
      check("reset remainder", int'(bus4.remainder), 0);
      check("reset dbz", int'(bus4.div_by_zero), 0);
      rst = 1'b0;

      // 9/2 timing: busy for 4 cycles, done 5 cycles after acceptance.
      issue4(9, 2, 1'b1);
      measure4(lat, bcnt);
      check("9/2 latency", lat, 5);
      check("9/2 busy cycles", bcnt, 4);
      @(negedge clk);
      check("9/2 done width", int'(bus4.done), 0);

      // Further directed pairs, done exactly one cycle wide.
      pa = '{15, 3, 9};
      pb = '{1, 7, 3};
      for (int i = 0; i < 3; i++) begin
         issue4(pa[i], pb[i], 1'b1);
         measure4(lat, bcnt);
         check("directed latency", lat, 5);
         @(negedge clk);
         check("directed done width", int'(bus4.done), 0);
      end

      // Divide by zero: latency 1, busy never high; then a normal op clears dbz.
      issue4(9, 0, 1'b1);
      measure4(lat, bcnt);
      check("9/0 latency", lat, 1);
      check("9/0 busy cycles", bcnt, 0);
      @(negedge clk);
      check("9/0 done width", int'(bus4.done), 0);
      issue4(6, 3, 1'b1);
      measure4(lat, bcnt);

      // start re-pulsed with new operands during RUN is ignored.
      issue4(9, 2, 1'b1);
      @(negedge clk);
      bus4.dividend = 4'd15;
      bus4.divisor  = 4'd1;
      bus4.start    = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      measure4(lat, bcnt);

      // start held high: second launch only after the IDLE cycle.
      @(negedge clk);
      bus4.dividend = 4'd6;
      bus4.divisor  = 4'd3;
      bus4.start    = 1'b1;
      sb4.push_back(model(6, 3, 4));
      sb4.push_back(model(6, 3, 4));
      first_done  = 0;
      second_done = 0;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n == 7) begin
            check("held start relaunch busy", int'(bus4.busy), 1);
            bus4.start = 1'b0;
         end
         if (bus4.done) begin
            if (first_done == 0) first_done = n;
            else if (second_done == 0) second_done = n;
         end
      end
      check("held start first done", first_done, 5);
      check("held start second done", second_done, 11);

      // Reset mid-RUN after E2 of 13/4: outputs clear asynchronously, no done.
      issue4(13, 4, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid-run rst busy", int'(bus4.busy), 0);
      check("mid-run rst done", int'(bus4.done), 0);
      check("mid-run rst quotient", int'(bus4.quotient), 0);
      check("mid-run rst remainder", int'(bus4.remainder), 0);
      check("mid-run rst dbz", int'(bus4.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus4.done) seen++;
      end
      check("no done after rst", seen, 0);
      issue4(13, 4, 1'b1);
      measure4(lat, bcnt);
      check("13/4 after rst latency", lat, 5);

      // Exhaustive WIDTH=4 sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            issue4(a, b, 1'b1);
         end
      end

      // Random WIDTH=8 vectors, roughly one in ten with a zero divisor.
      for (int i = 0; i < 200; i++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 255));
         b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
         issue8(a, b);
      end
      issue8(255, 1);
      issue8(0, 255);

      // Drain both scoreboards with a bounded wait.
      for (int t = 0; t < 200 && (sb4.size() != 0 || sb8.size() != 0); t++) begin
         @(negedge clk);
      end
      check("w4 scoreboard drained", sb4.size(), 0);
      check("w8 scoreboard drained", sb8.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
